adder_share_arbiter: RTL
========================

# adder_share_arbiter

Round-robin scheduler that shares one WIDTH-bit adder datapath between NUM_REQ independent requesters. Each requester presents operands over a valid/ready handshake. The block grants one request per cycle, registers the granted operands, and computes a + b + cin with carry-out and signed overflow. It returns a tagged, registered result on a single response channel with backpressure. It sits between the adder implementations and any client units (address generation, accumulators) that need occasional 32-bit adds.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- WIDTH, 32: operand/sum width.
- IDW, $clog2(NUM_REQ): requester-id width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of requester that owns the response.
- rsp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- rsp_overflow  out  1  signed overflow: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).

## Operation
- Two register stages: S1 (operand register: op_v, op_id, op_a, op_b, op_cin) and S2 (response register driving all rsp_* outputs).
- S2 load condition: s2_adv = !rsp_valid || rsp_ready. When s2_adv is high, S2 takes the adder result of S1 and rsp_valid <= op_v.
- S1 load condition: s1_adv = !op_v || s2_adv. When s1_adv is high, S1 takes the granted request, or op_v <= 0 if there is no request.
- Arbitration is combinational from req_valid and the round-robin pointer rr_ptr (IDW bits). The grant goes to the first valid requester at index rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
- req_ready[g] = s1_adv && req_valid[g] for the granted g. All other bits are 0.
- A transfer occurs when req_valid[i] && req_ready[i]. On a transfer, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Adder: a single combinational WIDTH+1-bit add of op_a + op_b + op_cin, from which sum and cout are taken. Overflow uses the formula in the Interface section.
- The response hold rule: while rsp_valid && !rsp_ready, all rsp_* outputs are stable.
- Requesters may drop req_valid without a transfer. The arbiter makes no fairness guarantee for requests that are withdrawn.

## Timing
- Reset (rst_n low at a clk edge) clears op_v, rsp_valid, rr_ptr, rsp_id, rsp_sum, rsp_cout and rsp_overflow to 0. req_ready is 0 while rst_n is low.
- Reset mid-operation discards the in-flight S1/S2 contents without emitting a response.
- Latency: a request accepted at edge N appears with rsp_valid high after edge N+1. This holds when S2 is not stalled.
- Throughput: one result per cycle while rsp_ready is held high.
- Full condition: with op_v=1, rsp_valid=1 and rsp_ready=0, req_ready is all-zero and rr_ptr holds.
- Simultaneous events:
  - If rsp_ready rises in the same cycle as a new request, S2 drains, S1 advances and the new request is accepted in that same cycle. There is no bubble.
- rr_ptr wrap-around: a grant to requester NUM_REQ-1 sets rr_ptr to 0.

## Configuration
- ADDER_ARB_FIXED_PRIO_EN defined: fixed priority, with the lowest index winning. rr_ptr is removed or ignored and the search always starts at 0.
- ADDER_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0000, rsp_valid=0, rsp_sum=0. Release -> first grant goes to requester 0.
- Positive overflow:
  - Stimulus: requester 2 only, a=7FFFFFFF, b=00000001, cin=0.
  - Response: rsp_valid 2 cycles after rst_n release plus acceptance, with rsp_id=2, rsp_sum=80000000, rsp_cout=0, rsp_overflow=1.
- Negative overflow with carry-in:
  - Stimulus: a=80000000, b=FFFFFFFF, cin=1.
  - Response: rsp_sum=80000000, rsp_cout=1, rsp_overflow=0.
  - Stimulus: a=80000000, b=FFFFFFFF, cin=0.
  - Response: rsp_sum=7FFFFFFF, rsp_cout=1, rsp_overflow=1.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid with a=i, b=10h, cin=0, and rsp_ready=1.
  - Response: rsp_id sequence 0,1,2,3,0,…, with sums 10h,11h,12h,13h, one response per cycle.
  - Fixed-priority build: rsp_id stays 0 for every response.
- Backpressure:
  - Stimulus: hold rsp_ready=0 after a first request (a=5, b=FFFFFFFD).
  - Response: rsp_sum=00000002 held stable, a second request is accepted into S1, then req_ready=0000.
  - Raise rsp_ready -> both results drain in order on consecutive cycles.
- Withdrawal:
  - Stimulus: requester 1 asserts valid for one cycle while S1 and S2 are full, then drops it.
  - Response: no transfer and no response with rsp_id=1. rr_ptr is unchanged.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between NUM_REQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_overflow
);

    logic               op_v;
    logic [IDW-1:0]     op_id;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_cin;

    logic               s2_adv;
    logic               s1_adv;
    logic               xfer;

    logic [IDW-1:0]     start_idx;
    logic [NUM_REQ-1:0] rot_valid;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_id;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;

    logic [WIDTH:0]     add_full;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               add_ovf;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

    logic [IDW-1:0] rr_ptr;

    assign start_idx = rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
        end
    end
`endif

    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !op_v || s2_adv;

    // Rotate the valids so bit 0 is the search start, take the lowest set bit,
    // then map the rotated position back to a requester index.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        int pick;
        int g;
        rot_valid = NUM_REQ'({req_valid, req_valid} >> start_idx);
        gnt_found = |rot_valid;
        pick      = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot_valid[j]) pick = j;
        end
        g       = (int'(start_idx) + pick) % NUM_REQ;
        gnt_id  = g[IDW-1:0];
        gnt_oh  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_found && i == g) begin
                gnt_oh[i] = 1'b1;
                sel_a     = req_a[i*WIDTH +: WIDTH];
                sel_b     = req_b[i*WIDTH +: WIDTH];
                sel_cin   = req_cin[i];
            end
        end
    end

    assign req_ready = (rst_n && s1_adv) ? gnt_oh : '0;
    assign xfer      = rst_n && s1_adv && gnt_found;

    assign add_full = {1'b0, op_a} + {1'b0, op_b} + (WIDTH + 1)'(op_cin);
    assign add_sum  = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];
    assign add_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_v         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            if (s2_adv) begin
                rsp_valid <= op_v;
                if (op_v) begin
                    rsp_id       <= op_id;
                    rsp_sum      <= add_sum;
                    rsp_cout     <= add_cout;
                    rsp_overflow <= add_ovf;
                end
            end
            if (s1_adv) begin
                op_v <= gnt_found;
            end
        end
    end

    // NOTE: operand registers carry no reset; op_v alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (xfer) begin
            op_id  <= gnt_id;
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_cin <= sel_cin;
        end
    end

endmodule
